// File: rtl/division_apply_pkg.sv
// Shared types and helpers for the sequential element-wise divide block.
// Optional feature macro used by the block: DIVAPPLY_REM_EN (remainder output).
package division_apply_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIter,
        StFix,
        StDone
    } state_e;

    typedef struct packed {
        logic is_signed;
        logic rem;
    } mode_t;

    // Width of a length field that can count 0..lanes inclusive.
    function automatic int unsigned len_w(int unsigned lanes);
        return $clog2(lanes + 1);
    endfunction

    // Most negative two's-complement value of the given width, zero-extended to 64 bits.
    function automatic logic [63:0] min_val(int unsigned w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/division_apply_seq_if.sv
// Beat-level handshake bundle for division_apply_seq (input beat, result beat, flush).
interface division_apply_seq_if
    import division_apply_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LANES  = 8,
    parameter int unsigned LEN_W  = len_w(LANES)
) ();

    logic                    flush;
    logic                    in_valid;
    logic                    in_ready;
    logic [LEN_W-1:0]        in_len;
    logic                    in_signed;
    logic                    in_rem;
    logic [LANES*DATA_W-1:0] in_dvd;
    logic [LANES*DATA_W-1:0] in_dvs;
    logic                    out_valid;
    logic                    out_ready;
    logic [LANES*DATA_W-1:0] out_res;
    logic [LANES-1:0]        out_div0;

    modport master (
        output flush, in_valid, in_len, in_signed, in_rem, in_dvd, in_dvs, out_ready,
        input  in_ready, out_valid, out_res, out_div0
    );

    modport slave (
        input  flush, in_valid, in_len, in_signed, in_rem, in_dvd, in_dvs, out_ready,
        output in_ready, out_valid, out_res, out_div0
    );

endinterface

// File: rtl/div_lane_step.sv
// One combinational radix-2 restoring division step for a single lane.
module div_lane_step #(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W:0]   rem_i,
    input  logic [DATA_W-1:0] quo_i,
    input  logic [DATA_W-1:0] dvs_i,
    output logic [DATA_W:0]   rem_o,
    output logic [DATA_W-1:0] quo_o
);

    logic [DATA_W:0] shifted;
    logic [DATA_W:0] diff;
    // The partial remainder always stays below the divisor, so its MSB never feeds the shift.
    logic            unused_rem_msb;

    assign unused_rem_msb = rem_i[DATA_W];

    // Shift {rem, quo} left, trial-subtract the divisor, keep the difference if non-negative.
    always_comb begin
        shifted = {rem_i[DATA_W-1:0], quo_i[DATA_W-1]};
        diff    = shifted - {1'b0, dvs_i};
        if (!diff[DATA_W]) begin
            rem_o = diff;
            quo_o = {quo_i[DATA_W-2:0], 1'b1};
        end else begin
            rem_o = shifted;
            quo_o = {quo_i[DATA_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/division_apply_seq.sv
// Multi-cycle element-wise divider: one beat of LANES pairs, shared restoring iteration.
// Optional feature: define DIVAPPLY_REM_EN to honour in_rem and return signed remainders.
module division_apply_seq
    import division_apply_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LANES  = 8,
    parameter int unsigned LEN_W  = len_w(LANES)
) (
    input logic                clk,
    input logic                rst_n,
    division_apply_seq_if.slave bus
);

    localparam int unsigned      CntW   = $clog2(DATA_W);
    localparam logic [DATA_W-1:0] MinVal = DATA_W'(min_val(DATA_W));

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              accept;
    logic [LEN_W-1:0]  len_s;

    mode_t             mode_q, mode_in;
    logic [LANES-1:0]  mask_q, mask_in;
    logic [LANES-1:0]  qneg_q, qneg_in;
    logic [LANES-1:0]  rneg_q, rneg_in;
    logic [LANES-1:0]  zero_q, zero_in;
    logic [LANES-1:0]  ovf_q, ovf_in;

    logic [DATA_W-1:0] dvd_q   [LANES];
    logic [DATA_W-1:0] dvs_q   [LANES];
    logic [DATA_W-1:0] quo_q   [LANES];
    logic [DATA_W:0]   rem_q   [LANES];
    logic [DATA_W-1:0] dvd_in  [LANES];
    logic [DATA_W-1:0] dvda_in [LANES];
    logic [DATA_W-1:0] dvsa_in [LANES];
    logic [DATA_W-1:0] quo_nxt [LANES];
    logic [DATA_W:0]   rem_nxt [LANES];

    logic [LANES*DATA_W-1:0] res_q, fix_res;
    logic [LANES-1:0]        div0_q, fix_div0;

    assign len_s  = bus.in_len;
    assign accept = (state_q == StIdle) && bus.in_valid && !bus.flush;

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.out_res   = res_q;
    assign bus.out_div0  = div0_q;

    // State and iteration counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; flush wins over every other input.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.flush) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        state_d = StIter;
                        cnt_d   = CntW'(DATA_W - 1);
                    end
                end
                StIter: begin
                    if (cnt_q == '0) state_d = StFix;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                StFix:  state_d = StDone;
                StDone: if (bus.out_ready) state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // Accept-time decode: operand magnitudes, result signs and special-case flags per lane.
    always_comb begin
        mode_in.is_signed = bus.in_signed;
`ifdef DIVAPPLY_REM_EN
        mode_in.rem = bus.in_rem;
`else
        mode_in.rem = 1'b0;
`endif
        mask_in = '0;
        qneg_in = '0;
        rneg_in = '0;
        zero_in = '0;
        ovf_in  = '0;
        for (int i = 0; i < LANES; i++) begin
            logic [DATA_W-1:0] dvs_raw;
            logic              dvd_neg, dvs_neg;
            dvd_in[i]  = bus.in_dvd[i*DATA_W +: DATA_W];
            dvs_raw    = bus.in_dvs[i*DATA_W +: DATA_W];
            dvd_neg    = bus.in_signed & dvd_in[i][DATA_W-1];
            dvs_neg    = bus.in_signed & dvs_raw[DATA_W-1];
            dvda_in[i] = dvd_neg ? -dvd_in[i] : dvd_in[i];
            dvsa_in[i] = dvs_neg ? -dvs_raw : dvs_raw;
            qneg_in[i] = dvd_neg ^ dvs_neg;
            rneg_in[i] = dvd_neg;
            // Lengths above LANES naturally enable every lane here.
            mask_in[i] = (int'(len_s) > i);
            zero_in[i] = (dvs_raw == '0);
            ovf_in[i]  = bus.in_signed && (dvd_in[i] == MinVal) && (dvs_raw == '1);
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        div_lane_step #(
            .DATA_W (DATA_W)
        ) u_step (
            .rem_i (rem_q[g]),
            .quo_i (quo_q[g]),
            .dvs_i (dvs_q[g]),
            .rem_o (rem_nxt[g]),
            .quo_o (quo_nxt[g])
        );
    end

    // Sign fix-up and special-case override, consumed on the FIX cycle.
    always_comb begin
        fix_res  = '0;
        fix_div0 = '0;
        for (int i = 0; i < LANES; i++) begin
            logic [DATA_W-1:0] q;
            q = qneg_q[i] ? -quo_q[i] : quo_q[i];
            if (zero_q[i])     q = '1;
            else if (ovf_q[i]) q = MinVal;
`ifdef DIVAPPLY_REM_EN
            begin
                logic [DATA_W-1:0] r;
                r = rneg_q[i] ? -rem_q[i][DATA_W-1:0] : rem_q[i][DATA_W-1:0];
                if (zero_q[i])     r = dvd_q[i];
                else if (ovf_q[i]) r = '0;
                if (mode_q.rem) q = r;
            end
`endif
            if (mask_q[i]) begin
                fix_res[i*DATA_W +: DATA_W] = q;
                fix_div0[i]                 = zero_q[i];
            end else begin
                fix_res[i*DATA_W +: DATA_W] = dvd_q[i];
            end
        end
    end

`ifndef DIVAPPLY_REM_EN
    // Remainder is only needed inside the iteration when the remainder feature is off.
    logic unused_rem_mode;
    assign unused_rem_mode = bus.in_rem ^ mode_q.rem ^ (^rneg_q);
`endif

    // Operand capture on accept, iteration during ITER, result capture on FIX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= '0;
            mask_q <= '0;
            qneg_q <= '0;
            rneg_q <= '0;
            zero_q <= '0;
            ovf_q  <= '0;
            res_q  <= '0;
            div0_q <= '0;
            for (int i = 0; i < LANES; i++) begin
                dvd_q[i] <= '0;
                dvs_q[i] <= '0;
                quo_q[i] <= '0;
                rem_q[i] <= '0;
            end
        end else begin
            if (accept) begin
                mode_q <= mode_in;
                mask_q <= mask_in;
                qneg_q <= qneg_in;
                rneg_q <= rneg_in;
                zero_q <= zero_in;
                ovf_q  <= ovf_in;
                for (int i = 0; i < LANES; i++) begin
                    dvd_q[i] <= dvd_in[i];
                    dvs_q[i] <= dvsa_in[i];
                    quo_q[i] <= dvda_in[i];
                    rem_q[i] <= '0;
                end
            end else if (state_q == StIter && !bus.flush) begin
                for (int i = 0; i < LANES; i++) begin
                    quo_q[i] <= quo_nxt[i];
                    rem_q[i] <= rem_nxt[i];
                end
            end
            if (state_q == StFix && !bus.flush) begin
                res_q  <= fix_res;
                div0_q <= fix_div0;
            end
        end
    end

endmodule

// File: tb/tb_division_apply_seq.sv
// Directed self-checking bench for division_apply_seq (DATA_W = 32, LANES = 8).
module tb_division_apply_seq;

    localparam int unsigned W = 32;
    localparam int unsigned L = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   edges;
    logic saw_valid;
    logic [31:0] dvd_v [L];
    logic [31:0] dvs_v [L];
    logic [31:0] exp_v [L];
    logic [31:0] held;

    division_apply_seq_if #(.DATA_W(W), .LANES(L)) bus ();

    division_apply_seq #(.DATA_W(W), .LANES(L)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat from dvd_v/dvs_v; returns just after the accepting edge.
    task automatic start_beat(input int len, input logic sgn, input logic rem);
        for (int i = 0; i < L; i++) begin
            bus.in_dvd[i*W +: W] = dvd_v[i];
            bus.in_dvs[i*W +: W] = dvs_v[i];
        end
        bus.in_len    = 4'(len);
        bus.in_signed = sgn;
        bus.in_rem    = rem;
        bus.in_valid  = 1'b1;
        step();
        bus.in_valid  = 1'b0;
        // Garbage after accept must be ignored.
        bus.in_dvd    = '1;
        bus.in_dvs    = '0;
        bus.in_signed = ~sgn;
        bus.in_rem    = ~rem;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            step();
            n++;
        end
    endtask

    task automatic check_lanes(input string tag);
        for (int i = 0; i < L; i++)
            chk($sformatf("%s_lane%0d", tag, i), bus.out_res[i*W +: W], exp_v[i]);
    endtask

    task automatic release_beat();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        bus.flush = 0; bus.in_valid = 0; bus.in_len = '0; bus.in_signed = 0;
        bus.in_rem = 0; bus.in_dvd = '0; bus.in_dvs = '0; bus.out_ready = 0;
        #12;
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_res", 32'(|bus.out_res), 0);
        chk("rst_out_div0", 32'(bus.out_div0), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Signed quotients, full length, latency 33 edges.
        dvd_v = '{-67, -15, -24, 47, 26, 186, -255, 34567};
        dvs_v = '{10, -35, 24, -47, 70, 57, -375, 357};
        exp_v = '{-6, 0, -1, -1, 0, 3, 0, 96};
        start_beat(8, 1'b1, 1'b0);
        chk("busy_in_ready", 32'(bus.in_ready), 0);
        wait_done(edges);
        chk("latency", edges, 33);
        check_lanes("sq");
        chk("sq_div0", 32'(bus.out_div0), 0);
        release_beat();
        chk("rel_in_ready", 32'(bus.in_ready), 1);
        chk("rel_out_valid", 32'(bus.out_valid), 0);

`ifdef DIVAPPLY_REM_EN
        exp_v = '{-7, -15, 0, 0, 26, 15, -255, 295};
        start_beat(8, 1'b1, 1'b1);
        wait_done(edges);
        check_lanes("srem");
        release_beat();
`endif

        // Length limit: lanes 3..7 pass through.
        dvd_v = '{10, 11, 12, 13, 14, 15, 16, 17};
        dvs_v = '{2, 2, 2, 2, 2, 2, 2, 2};
        exp_v = '{5, 5, 6, 13, 14, 15, 16, 17};
        start_beat(3, 1'b1, 1'b0);
        wait_done(edges);
        check_lanes("len3");

        // Hold the result for 5 cycles, then release and accept back-to-back.
        held = bus.out_res[2*W +: W];
        for (int c = 0; c < 5; c++) begin
            step();
            chk($sformatf("stall%0d_valid", c), 32'(bus.out_valid), 1);
            chk($sformatf("stall%0d_ready", c), 32'(bus.in_ready), 0);
            chk($sformatf("stall%0d_res", c), bus.out_res[2*W +: W], held);
        end
        release_beat();
        chk("b2b_in_ready", 32'(bus.in_ready), 1);

        // Special cases, signed: x/0, MIN/-1, ordinary lane, pass-through lanes.
        dvd_v = '{5, 32'h8000_0000, 7, 1, 2, 3, 4, 5};
        dvs_v = '{0, 32'hFFFF_FFFF, -2, 0, 0, 0, 0, 0};
        exp_v = '{32'hFFFF_FFFF, 32'h8000_0000, -3, 1, 2, 3, 4, 5};
        start_beat(3, 1'b1, 1'b0);
        chk("b2b_accepted", 32'(bus.in_ready), 0);
        wait_done(edges);
        check_lanes("spec");
        chk("spec_div0", 32'(bus.out_div0), 32'h01);
        release_beat();

        // Unsigned, with len above LANES clamped to all lanes.
        dvd_v = '{32'hFFFF_FFF6, 32'h8000_0000, 100, 0, 9, 9, 9, 9};
        dvs_v = '{10, 32'hFFFF_FFFF, 0, 3, 9, 9, 9, 9};
        exp_v = '{429496728, 0, 32'hFFFF_FFFF, 0, 1, 1, 1, 1};
        start_beat(9, 1'b0, 1'b0);
        wait_done(edges);
        check_lanes("uns");
        chk("uns_div0", 32'(bus.out_div0), 32'h04);
        release_beat();
`ifdef DIVAPPLY_REM_EN
        exp_v = '{6, 32'h8000_0000, 100, 0, 0, 0, 0, 0};
        start_beat(8, 1'b0, 1'b1);
        wait_done(edges);
        check_lanes("urem");
        release_beat();
`endif

        // Flush at ITER cycle 10: back to IDLE, no result presented.
        start_beat(8, 1'b0, 1'b0);
        for (int c = 0; c < 10; c++) step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("flush_in_ready", 32'(bus.in_ready), 1);
        saw_valid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            step();
            saw_valid |= bus.out_valid;
        end
        chk("flush_no_valid", 32'(saw_valid), 0);

        // Flush together with in_valid in IDLE: beat not accepted.
        bus.flush = 1'b1;
        bus.in_valid = 1'b1;
        step();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_idle_noacc", 32'(bus.in_ready), 1);

        // Asynchronous reset mid-ITER clears outputs before the next edge.
        start_beat(8, 1'b0, 1'b0);
        for (int c = 0; c < 10; c++) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", 32'(bus.in_ready), 1);
        chk("arst_out_valid", 32'(bus.out_valid), 0);
        chk("arst_out_res", 32'(|bus.out_res), 0);
        chk("arst_out_div0", 32'(bus.out_div0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            step();
            saw_valid |= bus.out_valid;
        end
        chk("arst_no_valid", 32'(saw_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
